relobi_mem_sbr: RTL and testbench

Reliable-OBI subordinate endpoint: a small ECC-protected register memory that answers the requests a `relobi` crossbar manager port emits. Voting on the triplicated handshake, Hsiao decoding of address and write data, byte-enabled storage of ECC-encoded words, and responses with re-encoded read data through a bounded response FIFO. Used as scratchpad/CSR backing store and as the reference responder in crossbar benches.

---
 rtl/relobi_mem_sbr.sv | 201 ++++++++++++++++++++
 tb/tb_relobi_mem_sbr.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relobi_mem_sbr.sv
// Reliable-OBI subordinate: ECC-protected register memory behind a voted request/response handshake.
// Address, write data and stored words are Hsiao (39,32) SECDED codewords; responses leave through a small FIFO.
module relobi_mem_sbr #(
    parameter int unsigned NumWords    = 16,
    parameter logic [31:0] BaseAddr    = 32'h0,
    parameter int unsigned IdWidth     = 1,
    parameter int unsigned NumMaxTrans = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [2:0]         req_i,
    output logic [2:0]         gnt_o,
    input  logic [38:0]        addr_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [38:0]        wdata_i,
    input  logic [IdWidth-1:0] aid_i,
    output logic [2:0]         rvalid_o,
    input  logic [2:0]         rready_i,
    output logic [38:0]        rdata_o,
    output logic [IdWidth-1:0] rid_o,
    output logic               err_o,
    output logic [1:0]         fault_o
);

    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned PtrW     = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int unsigned CntW     = $clog2(NumMaxTrans + 1);
    localparam int unsigned EntW     = 39 + IdWidth + 1;
    localparam logic [31:0] MemBytes = 32'(NumWords * 4);
    localparam logic [31:0] ErrData  = 32'hBADCAB1E;

    typedef logic [6:0][31:0] mask_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sbe;
        logic        dbe;
    } dec_t;

    // Data column j is the j-th smallest 7-bit value of weight three; check bits use unit columns.
    function automatic mask_t gen_masks();
        mask_t       m;
        int          n;
        logic [6:0]  c;
        m = '0;
        n = 0;
        for (int v = 0; v < 128; v++) begin
            c = v[6:0];
            if ($countones(c) == 3 && n < 32) begin
                for (int k = 0; k < 7; k++) m[k][n] = c[k];
                n++;
            end
        end
        return m;
    endfunction

    localparam mask_t HMask = gen_masks();

    function automatic logic [6:0] hsiao_ecc(input logic [31:0] d);
        logic [6:0] e;
        for (int k = 0; k < 7; k++) e[k] = ^(d & HMask[k]);
        return e;
    endfunction

    function automatic logic [38:0] hsiao_enc(input logic [31:0] d);
        return {hsiao_ecc(d), d};
    endfunction

    // Odd syndromes that match no column are treated as uncorrectable.
    function automatic dec_t hsiao_dec(input logic [38:0] cw);
        dec_t       r;
        logic [6:0] syn;
        logic [6:0] col;
        logic       hit;
        r.data = cw[31:0];
        r.sbe  = 1'b0;
        r.dbe  = 1'b0;
        syn    = cw[38:32] ^ hsiao_ecc(cw[31:0]);
        if (syn != 7'd0) begin
            if (^syn) begin
                hit = ($countones(syn) == 1);
                for (int j = 0; j < 32; j++) begin
                    for (int k = 0; k < 7; k++) col[k] = HMask[k][j];
                    if (col == syn) begin
                        r.data[j] = ~r.data[j];
                        hit       = 1'b1;
                    end
                end
                r.sbe = hit;
                r.dbe = !hit;
            end else begin
                r.dbe = 1'b1;
            end
        end
        return r;
    endfunction

    logic [NumWords-1:0][38:0] mem_q;
    logic [EntW-1:0]           fifo_q [NumMaxTrans];
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]           count_q;
    logic [1:0]                fault_q;

    logic        req_v, rready_v, vote_err;
    logic        fifo_full, fifo_empty, gnt, pop;
    dec_t        addr_dec, wdata_dec, mem_dec;
    logic [31:0] offset, merged;
    logic        in_range;
    logic [IdxW-1:0] idx;
    logic [38:0] mem_word, rsp_data, mem_wdata;
    logic        rsp_err, mem_we, f_corr, f_unc;
    logic [EntW-1:0] head;

    assign req_v    = (req_i[0] & req_i[1]) | (req_i[0] & req_i[2]) | (req_i[1] & req_i[2]);
    assign rready_v = (rready_i[0] & rready_i[1]) | (rready_i[0] & rready_i[2]) | (rready_i[1] & rready_i[2]);
    assign vote_err = (req_i != {3{req_i[0]}}) || (rready_i != {3{rready_i[0]}});

    // A-channel beat is accepted when gnt; R-channel beat leaves when rvalid and voted rready.
    // A full FIFO never grants, even if it is popped in the same cycle.
    assign fifo_full  = (count_q == CntW'(NumMaxTrans));
    assign fifo_empty = (count_q == '0);
    assign gnt        = req_v && !fifo_full;
    assign pop        = !fifo_empty && rready_v;

    always_comb begin
        addr_dec  = hsiao_dec(addr_i);
        wdata_dec = hsiao_dec(wdata_i);
        offset    = addr_dec.data - BaseAddr;
        in_range  = (offset < MemBytes);
        idx       = offset[2 +: IdxW];
        mem_word  = mem_q[idx];
        mem_dec   = hsiao_dec(mem_word);
        merged    = mem_dec.data;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) merged[8*b +: 8] = wdata_dec.data[8*b +: 8];
        end
        rsp_data  = hsiao_enc(ErrData);
        rsp_err   = 1'b1;
        mem_we    = 1'b0;
        mem_wdata = hsiao_enc(merged);
        f_corr    = vote_err;
        f_unc     = 1'b0;
        if (gnt) begin
            f_corr = f_corr | addr_dec.sbe | (we_i & wdata_dec.sbe);
            f_unc  = addr_dec.dbe | (we_i & wdata_dec.dbe);
            if (!addr_dec.dbe && in_range) begin
                if (we_i) begin
                    rsp_data = hsiao_enc(32'h0);
                    rsp_err  = wdata_dec.dbe;
                    mem_we   = !wdata_dec.dbe;
                end else if (mem_dec.dbe) begin
                    rsp_data = mem_word;
                    f_unc    = 1'b1;
                end else begin
                    // Correctable stored errors are scrubbed with the corrected codeword.
                    rsp_data  = hsiao_enc(mem_dec.data);
                    rsp_err   = 1'b0;
                    f_corr    = f_corr | mem_dec.sbe;
                    mem_we    = mem_dec.sbe;
                    mem_wdata = rsp_data;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fault_q  <= '0;
            for (int i = 0; i < int'(NumMaxTrans); i++) fifo_q[i] <= '0;
        end else begin
            fault_q <= {f_unc, f_corr};
            if (mem_we) mem_q[idx] <= mem_wdata;
            if (gnt) begin
                fifo_q[wr_ptr_q] <= {rsp_data, aid_i, rsp_err};
                wr_ptr_q <= (wr_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(NumMaxTrans - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({gnt, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign head     = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    assign gnt_o    = {3{gnt}};
    assign rvalid_o = {3{!fifo_empty}};
    assign rdata_o  = head[EntW-1 -: 39];
    assign rid_o    = head[1 +: IdWidth];
    assign err_o    = head[0];
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_relobi_mem_sbr.sv
// Bench for relobi_mem_sbr: directed vector table, hand-written corner sequences and a random run
// checked against a word-level model with an in-order response queue.
module tb_relobi_mem_sbr;

    localparam int          NW   = 16;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam int          IW   = 2;
    localparam int          NMT  = 2;
    localparam int          EW   = 39 + IW + 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [2:0]    req_i;
    logic [2:0]    gnt_o;
    logic [38:0]   addr_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [38:0]   wdata_i;
    logic [IW-1:0] aid_i;
    logic [2:0]    rvalid_o;
    logic [2:0]    rready_i;
    logic [38:0]   rdata_o;
    logic [IW-1:0] rid_o;
    logic          err_o;
    logic [1:0]    fault_o;

    relobi_mem_sbr #(
        .NumWords(NW),
        .BaseAddr(BASE),
        .IdWidth(IW),
        .NumMaxTrans(NMT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_i(req_i),
        .gnt_o(gnt_o),
        .addr_i(addr_i),
        .we_i(we_i),
        .be_i(be_i),
        .wdata_i(wdata_i),
        .aid_i(aid_i),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .rdata_o(rdata_o),
        .rid_o(rid_o),
        .err_o(err_o),
        .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [EW-1:0]   exp_q[$];
    logic [31:0]     m_data [NW];
    logic            m_bad [NW];
    logic [1:0]      exp_fault;
    logic [6:0]      cols [32];

    typedef struct {
        logic          we;
        logic [3:0]    be;
        logic [31:0]   off;
        logic [31:0]   wdata;
        logic [IW-1:0] id;
        logic          exp_err;
        logic [31:0]   exp_data;
    } vec_t;

    vec_t vecs [13];

    // Weight-three columns in increasing numeric order: highest set bit first, then the lower two.
    task automatic build_cols();
        int n;
        logic [6:0] c;
        n = 0;
        for (int k = 2; k < 7; k++)
            for (int j = 1; j < k; j++)
                for (int i = 0; i < j; i++) begin
                    if (n < 32) begin
                        c = '0;
                        c[k] = 1'b1;
                        c[j] = 1'b1;
                        c[i] = 1'b1;
                        cols[n] = c;
                        n++;
                    end
                end
    endtask

    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [6:0] e;
        e = '0;
        for (int j = 0; j < 32; j++) if (d[j]) e = e ^ cols[j];
        return {e, d};
    endfunction

    function automatic logic [38:0] rand_mask(input int n);
        logic [38:0] m;
        int a, b;
        m = '0;
        if (n > 0) begin
            a = $urandom_range(0, 38);
            m[a] = 1'b1;
            if (n > 1) begin
                b = $urandom_range(0, 38);
                while (b == a) b = $urandom_range(0, 38);
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NW; i++) begin
            m_data[i] = '0;
            m_bad[i]  = 1'b0;
        end
        exp_fault = 2'b00;
    endtask

    // One bus cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic [2:0] rq, input logic [2:0] rd, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [38:0] amask, input logic [31:0] wdata,
                        input logic [38:0] wmask, input logic [IW-1:0] id, output logic g);
        logic        rv, rdv, inr;
        logic [1:0]  f;
        logic [31:0] off;
        logic [38:0] rsp_d;
        logic        rsp_e;
        int          ac, wc, k;
        @(negedge clk);
        req_i    = rq;
        rready_i = rd;
        we_i     = we;
        be_i     = be;
        addr_i   = enc(addr) ^ amask;
        wdata_i  = enc(wdata) ^ wmask;
        aid_i    = id;
        #1;
        rv  = ($countones(rq) >= 2);
        rdv = ($countones(rd) >= 2);
        g   = rv && (exp_q.size() < NMT);
        check("fault", {62'd0, fault_o}, {62'd0, exp_fault});
        check("gnt", {61'd0, gnt_o}, {61'd0, {3{g}}});
        check("rvalid", {61'd0, rvalid_o}, {61'd0, {3{exp_q.size() != 0}}});
        if (exp_q.size() != 0) check("rsp", {22'd0, rdata_o, rid_o, err_o}, {22'd0, exp_q[0]});
        f = 2'b00;
        if (rq != {3{rq[0]}} || rd != {3{rd[0]}}) f[0] = 1'b1;
        if (exp_q.size() != 0 && rdv) void'(exp_q.pop_front());
        if (g) begin
            ac    = $countones(amask);
            wc    = $countones(wmask);
            off   = addr - BASE;
            inr   = (off < 32'(NW * 4));
            rsp_d = enc(32'hBADCAB1E);
            rsp_e = 1'b1;
            if (ac == 1) f[0] = 1'b1;
            if (ac == 2) f[1] = 1'b1;
            if (we && wc == 1) f[0] = 1'b1;
            if (we && wc == 2) f[1] = 1'b1;
            if (ac < 2 && inr) begin
                k = int'(off / 4);
                if (we) begin
                    rsp_d = enc(32'h0);
                    rsp_e = (wc == 2);
                    if (wc < 2) begin
                        for (int b = 0; b < 4; b++) if (be[b]) m_data[k][8*b +: 8] = wdata[8*b +: 8];
                        m_bad[k] = 1'b0;
                    end
                end else begin
                    rsp_d = enc(m_data[k]);
                    rsp_e = 1'b0;
                    if (m_bad[k]) f[0] = 1'b1;
                    m_bad[k] = 1'b0;
                end
            end
            exp_q.push_back({rsp_d, id, rsp_e});
        end
        exp_fault = f;
    endtask

    task automatic idle(input logic [2:0] rd);
        logic g;
        step(3'b000, rd, 1'b0, 4'h0, BASE, '0, 32'h0, '0, '0, g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i    = 1'b1;
        req_i    = 3'b000;
        rready_i = 3'b000;
        #1;
        check("rst_rvalid", {61'd0, rvalid_o}, 64'd0);
        check("rst_rdata", {25'd0, rdata_o}, 64'd0);
        check("rst_rid_err", {61'd0, rid_o, err_o}, 64'd0);
        check("rst_fault", {62'd0, fault_o}, 64'd0);
        check("rst_gnt", {61'd0, gnt_o}, 64'd0);
        clear_model();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Backdoor corruption of one stored bit; the memory keeps it once the force is released.
    task automatic inject(input int w, input int bitpos);
        logic [NW-1:0][38:0] img;
        img = dut.mem_q;
        img[w][bitpos] = ~img[w][bitpos];
        force dut.mem_q = img;
        #1;
        release dut.mem_q;
        m_bad[w] = 1'b1;
    endtask

    initial begin
        logic        g;
        logic [2:0]  rq, rd;
        logic [38:0] am, wm;
        logic [31:0] off;
        logic        gs [5];
        int          p;

        rst_i    = 1'b1;
        req_i    = '0;
        rready_i = '0;
        we_i     = 1'b0;
        be_i     = '0;
        addr_i   = '0;
        wdata_i  = '0;
        aid_i    = '0;
        build_cols();
        clear_model();

        vecs[0]  = '{1'b1, 4'hF, 32'd8,  32'hDEADBEEF, 2'd1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'hF, 32'd8,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'hF, 32'd12, 32'h11223344, 2'd3, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h5, 32'd12, 32'hAABBCCDD, 2'd0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'd12, 32'h0,        2'd1, 1'b0, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 4'h0, 32'd16, 32'hFFFFFFFF, 2'd2, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 4'h0, 32'd16, 32'h0,        2'd3, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 4'h0, 32'd64, 32'h0,        2'd0, 1'b1, 32'hBADCAB1E};
        vecs[8]  = '{1'b1, 4'hF, 32'd64, 32'h12345678, 2'd1, 1'b1, 32'hBADCAB1E};
        vecs[9]  = '{1'b0, 4'h0, 32'd60, 32'h0,        2'd2, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 4'hF, 32'd60, 32'hCAFEF00D, 2'd3, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'h0, 32'd61, 32'h0,        2'd0, 1'b0, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 4'h0, 32'hFFFFFFFC, 32'h0,  2'd1, 1'b1, 32'hBADCAB1E};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(3'b111, 3'b111, vecs[i].we, vecs[i].be, BASE + vecs[i].off, '0, vecs[i].wdata, '0, vecs[i].id, g);
            check("vec_gnt", {63'd0, g}, 64'd1);
            idle(3'b111);
            check("vec_rdata", {25'd0, rdata_o}, {25'd0, enc(vecs[i].exp_data)});
            check("vec_err", {63'd0, err_o}, {63'd0, vecs[i].exp_err});
            check("vec_rid", {62'd0, rid_o}, {62'd0, vecs[i].id});
        end

        // Address with one flipped bit, then two; the failed write must leave the word intact.
        am = '0;
        am[5] = 1'b1;
        step(3'b111, 3'b111, 1'b0, 4'h0, BASE + 8, am, 32'h0, '0, 2'd1, g);
        idle(3'b111);
        check("asbe_data", {25'd0, rdata_o}, {25'd0, enc(32'hDEADBEEF)});
        check("asbe_fault", {62'd0, fault_o}, 64'd1);
        am[9] = 1'b1;
        step(3'b111, 3'b111, 1'b1, 4'hF, BASE + 8, am, 32'h0, '0, 2'd2, g);
        idle(3'b111);
        check("adbe_err", {63'd0, err_o}, 64'd1);
        check("adbe_data", {25'd0, rdata_o}, {25'd0, enc(32'hBADCAB1E)});
        check("adbe_fault", {62'd0, fault_o}, 64'd2);
        step(3'b111, 3'b111, 1'b0, 4'h0, BASE + 8, '0, 32'h0, '0, 2'd3, g);
        idle(3'b111);
        check("adbe_keep", {25'd0, rdata_o}, {25'd0, enc(32'hDEADBEEF)});

        // Stored single-bit error: corrected on both reads, reported only on the first.
        inject(2, 3);
        step(3'b111, 3'b111, 1'b0, 4'h0, BASE + 8, '0, 32'h0, '0, 2'd0, g);
        idle(3'b111);
        check("scrub1_data", {25'd0, rdata_o}, {25'd0, enc(32'hDEADBEEF)});
        check("scrub1_fault", {62'd0, fault_o}, 64'd1);
        step(3'b111, 3'b111, 1'b0, 4'h0, BASE + 8, '0, 32'h0, '0, 2'd1, g);
        idle(3'b111);
        check("scrub2_data", {25'd0, rdata_o}, {25'd0, enc(32'hDEADBEEF)});
        check("scrub2_fault", {62'd0, fault_o}, 64'd0);

        // Backpressure: two reads fill the FIFO, the third waits until a pop frees a slot.
        step(3'b111, 3'b000, 1'b0, 4'h0, BASE + 8,  '0, 32'h0, '0, 2'd0, g); gs[0] = g;
        step(3'b111, 3'b000, 1'b0, 4'h0, BASE + 12, '0, 32'h0, '0, 2'd1, g); gs[1] = g;
        step(3'b111, 3'b000, 1'b0, 4'h0, BASE + 16, '0, 32'h0, '0, 2'd2, g); gs[2] = g;
        step(3'b111, 3'b111, 1'b0, 4'h0, BASE + 16, '0, 32'h0, '0, 2'd2, g); gs[3] = g;
        step(3'b111, 3'b111, 1'b0, 4'h0, BASE + 16, '0, 32'h0, '0, 2'd2, g); gs[4] = g;
        check("bp_gnt", {59'd0, gs[0], gs[1], gs[2], gs[3], gs[4]}, 64'b11001);
        idle(3'b111);
        idle(3'b111);
        idle(3'b111);

        // Vote disagreement on req: 011 votes to a request, 100 to none; both report a correctable fault.
        step(3'b011, 3'b111, 1'b0, 4'h0, BASE + 8, '0, 32'h0, '0, 2'd3, g);
        check("vote_gnt", {63'd0, g}, 64'd1);
        step(3'b100, 3'b111, 1'b0, 4'h0, BASE + 8, '0, 32'h0, '0, 2'd0, g);
        check("vote_nogrant", {63'd0, g}, 64'd0);
        check("vote_fault1", {62'd0, fault_o}, 64'd1);
        idle(3'b111);
        check("vote_fault2", {62'd0, fault_o}, 64'd1);
        idle(3'b111);

        // Reset with two responses queued drops them and clears every word.
        step(3'b111, 3'b000, 1'b0, 4'h0, BASE + 8,  '0, 32'h0, '0, 2'd1, g);
        step(3'b111, 3'b000, 1'b0, 4'h0, BASE + 12, '0, 32'h0, '0, 2'd2, g);
        do_reset();
        for (int i = 0; i < NW; i++) begin
            step(3'b111, 3'b111, 1'b0, 4'h0, BASE + 32'(4 * i), '0, 32'h0, '0, IW'(i), g);
        end
        idle(3'b111);
        idle(3'b111);

        // Random traffic with occasional vote glitches, ECC errors and out-of-range addresses.
        for (int i = 0; i < 500; i++) begin
            rq = {3{($urandom_range(0, 3) != 0)}};
            rd = {3{($urandom_range(0, 9) < 7)}};
            if ($urandom_range(0, 19) == 0) begin
                p = $urandom_range(0, 2);
                rq[p] = ~rq[p];
            end
            if ($urandom_range(0, 19) == 0) begin
                p = $urandom_range(0, 2);
                rd[p] = ~rd[p];
            end
            off = 32'($urandom_range(0, NW * 4 + 15));
            if ($urandom_range(0, 31) == 0) off = 32'hFFFFFFF0;
            p  = $urandom_range(0, 15);
            am = rand_mask((p == 0) ? 2 : (p < 3) ? 1 : 0);
            p  = $urandom_range(0, 15);
            wm = rand_mask((p == 0) ? 2 : (p < 3) ? 1 : 0);
            step(rq, rd, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), BASE + off, am,
                 $urandom, wm, IW'($urandom_range(0, 3)), g);
        end
        for (int i = 0; i < 4; i++) idle(3'b111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
